// File: rtl/fetch_unit_pkg.sv
// Constants shared by the fetch unit, CP0 and the pipeline-register blocks.
// Holds the exception codes, the default PC values and the next-PC source selector.
package fetch_unit_pkg;

    localparam logic [4:0] EXC_NONE = 5'd31;
    localparam logic [4:0] EXC_ADEL = 5'd4;

    localparam logic [31:0] PC_RESET_DEFAULT   = 32'h0000_3000;
    localparam logic [31:0] HANDLER_PC_DEFAULT = 32'h0000_4180;
    localparam logic [31:0] IM_LO_DEFAULT      = 32'h0000_3000;
    localparam logic [31:0] IM_HI_DEFAULT      = 32'h0000_6FFC;

    typedef enum logic [2:0] {
        NpcReset,
        NpcHandler,
        NpcHold,
        NpcEret,
        NpcRedirect,
        NpcSeq
    } npc_sel_e;

endpackage

// File: rtl/fetch_addr_check.sv
// Fetch address fault test: misaligned, or outside the inclusive instruction window.
module fetch_addr_check
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] IM_LO = IM_LO_DEFAULT,
    parameter logic [31:0] IM_HI = IM_HI_DEFAULT
) (
    input  logic [31:0] pc_i,
    output logic        fault_o
);

    always_comb begin
        fault_o = (pc_i[1:0] != 2'b00) || (pc_i < IM_LO) || (pc_i > IM_HI);
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, next-PC priority selection and fetch fault reporting.
// The fault is evaluated combinationally on the current PC; exceptions are only taken via req.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] PC_RESET   = PC_RESET_DEFAULT,
    parameter logic [31:0] HANDLER_PC = HANDLER_PC_DEFAULT,
    parameter logic [31:0] IM_LO      = IM_LO_DEFAULT,
    parameter logic [31:0] IM_HI      = IM_HI_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        frozen,
    input  logic        req,
    input  logic        eret,
    input  logic [31:0] epc,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    input  logic        d_is_branch,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc_out,
    output logic [31:0] instr_out,
    output logic [4:0]  exc_code_out,
    output logic        bd_out,
    output logic        eret_flush
);

    logic [31:0] pc_q, pc_d;
    npc_sel_e    npc_sel;
    logic        fault;

    // req beats frozen so an interrupt is never lost behind a stall; eret beats a redirect.
    always_comb begin
        npc_sel = NpcSeq;
        if (reset) begin
            npc_sel = NpcReset;
        end else if (req) begin
            npc_sel = NpcHandler;
        end else if (frozen) begin
            npc_sel = NpcHold;
        end else if (eret) begin
            npc_sel = NpcEret;
        end else if (redirect_valid) begin
            npc_sel = NpcRedirect;
        end
    end

    always_comb begin
        pc_d = pc_q + 32'd4;
        unique case (npc_sel)
            NpcReset:    pc_d = PC_RESET;
            NpcHandler:  pc_d = HANDLER_PC;
            NpcHold:     pc_d = pc_q;
            NpcEret:     pc_d = epc;
            NpcRedirect: pc_d = redirect_target;
            NpcSeq:      pc_d = pc_q + 32'd4;
            default:     pc_d = pc_q + 32'd4;
        endcase
    end

    always_ff @(posedge clk) begin
        pc_q <= pc_d;
    end

    fetch_addr_check #(
        .IM_LO (IM_LO),
        .IM_HI (IM_HI)
    ) u_addr_check (
        .pc_i    (pc_q),
        .fault_o (fault)
    );

    always_comb begin
        pc_out       = pc_q;
        imem_addr    = pc_q;
        exc_code_out = fault ? EXC_ADEL : EXC_NONE;
        instr_out    = fault ? 32'h0 : imem_rdata;
        // ERET has no delay slot, so it masks the delay-slot flag.
        bd_out       = d_is_branch && !eret;
        eret_flush   = eret && !frozen && !req && !reset;
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: expected fetch results are queued as each cycle is driven
// and compared after the clock edge that registers the new PC.
module tb_fetch_unit;

    localparam logic [31:0] PcReset   = 32'h0000_3000;
    localparam logic [31:0] HandlerPc = 32'h0000_4180;
    localparam logic [31:0] ImLo      = 32'h0000_3000;
    localparam logic [31:0] ImHi      = 32'h0000_6FFC;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        frozen = 1'b0;
    logic        req = 1'b0;
    logic        eret = 1'b0;
    logic [31:0] epc = 32'h0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_target = 32'h0;
    logic        d_is_branch = 1'b0;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] pc_out;
    logic [31:0] instr_out;
    logic [4:0]  exc_code_out;
    logic        bd_out;
    logic        eret_flush;

    typedef struct {
        string       tag;
        logic [31:0] pc;
        logic [4:0]  exc;
        logic [31:0] instr;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] model_pc;
    int          n_checks = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    // Simple pattern memory: every word address returns a distinct value.
    assign imem_rdata = {imem_addr[15:0], ~imem_addr[15:0]};

    fetch_unit dut (
        .clk             (clk),
        .reset           (reset),
        .frozen          (frozen),
        .req             (req),
        .eret            (eret),
        .epc             (epc),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .d_is_branch     (d_is_branch),
        .imem_addr       (imem_addr),
        .imem_rdata      (imem_rdata),
        .pc_out          (pc_out),
        .instr_out       (instr_out),
        .exc_code_out    (exc_code_out),
        .bd_out          (bd_out),
        .eret_flush      (eret_flush)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic is_fault(input logic [31:0] pc);
        return (pc[1:0] != 2'b00) || (pc < ImLo) || (pc > ImHi);
    endfunction

    // One clock cycle: drive inputs, check same-cycle outputs, queue and check the next fetch.
    task automatic cycle(input string tag, input logic rst, input logic fr, input logic rq,
                         input logic er, input logic [31:0] ep, input logic rv,
                         input logic [31:0] rt, input logic db);
        exp_t        e;
        exp_t        got;
        logic [31:0] nxt;
        @(negedge clk);
        reset = rst; frozen = fr; req = rq; eret = er; epc = ep;
        redirect_valid = rv; redirect_target = rt; d_is_branch = db;
        #1;
        check({tag, ".flush"}, {31'h0, eret_flush}, {31'h0, (er && !fr && !rq && !rst)});
        check({tag, ".bd"}, {31'h0, bd_out}, {31'h0, (db && !er)});
        if (rst)     nxt = PcReset;
        else if (rq) nxt = HandlerPc;
        else if (fr) nxt = model_pc;
        else if (er) nxt = ep;
        else if (rv) nxt = rt;
        else         nxt = model_pc + 32'd4;
        model_pc = nxt;
        e.tag   = tag;
        e.pc    = nxt;
        e.exc   = is_fault(nxt) ? 5'd4 : 5'd31;
        e.instr = is_fault(nxt) ? 32'h0 : {nxt[15:0], ~nxt[15:0]};
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            check({tag, ".queue"}, 32'h0, 32'h1);
        end else begin
            got = exp_q.pop_front();
            check({got.tag, ".pc"}, pc_out, got.pc);
            check({got.tag, ".imem_addr"}, imem_addr, got.pc);
            check({got.tag, ".exc"}, {27'h0, exc_code_out}, {27'h0, got.exc});
            check({got.tag, ".instr"}, instr_out, got.instr);
        end
    endtask

    task automatic free(input string tag);
        cycle(tag, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic jump(input string tag, input logic [31:0] target);
        cycle(tag, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, target, 1'b0);
    endtask

    initial begin
        model_pc = 32'h0;
        cycle("rst0", 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        cycle("rst1", 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        free("seq1");
        free("seq2");
        free("seq3");

        // Redirect held in D during a two-cycle stall, taken on the first unfrozen cycle.
        cycle("frz1", 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0000_3100, 1'b1);
        cycle("frz2", 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0000_3100, 1'b1);
        cycle("unfrz", 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0000_3100, 1'b1);

        jump("misal", 32'h0000_3102);
        free("misal_adv");

        jump("to3010", 32'h0000_3010);
        cycle("req_frz", 1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_3020, 1'b1, 32'h0000_3500, 1'b0);

        cycle("eret", 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_3020, 1'b1, 32'h0000_3400, 1'b1);
        cycle("eret_frz", 1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_3600, 1'b0, 32'h0, 1'b0);
        cycle("bd", 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);

        jump("to6ff8", 32'h0000_6FF8);
        free("at6ffc");
        free("at7000");

        jump("below", 32'h0000_2FFC);
        jump("top", 32'hFFFF_FFFC);
        free("wrap");

        cycle("rst_ovr", 1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_3020, 1'b1, 32'h0000_3400, 1'b1);
        free("post_rst");

        if (exp_q.size() != 0) check("drain", exp_q.size(), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter PC_RESET, default 32'h0000_3000, meaning the PC value after reset.
REQ-002 Parameter HANDLER_PC, default 32'h0000_4180, meaning the exception/interrupt entry address.
REQ-003 Parameters IM_LO/IM_HI, defaults 32'h0000_3000/32'h0000_6FFC, meaning the legal fetch window (inclusive).
REQ-004 clk  in  1  clock; all state updates on posedge clk.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 frozen  in  1  stall from hazard unit; hold PC.
REQ-007 req  in  1  CP0 exception/interrupt request; redirect to handler.
REQ-008 eret  in  1  ERET currently decoded in D stage.
REQ-009 epc  in  32  return address from CP0.
REQ-010 redirect_valid  in  1  branch/jump taken, resolved in D.
REQ-011 redirect_target  in  32  branch/jump target.
REQ-012 d_is_branch  in  1  D-stage instruction is a branch/jump; current F slot is a delay slot.
REQ-013 imem_addr  out  32  instruction memory word address (equals pc_out).
REQ-014 imem_rdata  in  32  instruction word, combinational read.
REQ-015 pc_out  out  32  current fetch PC, to the D pipeline register.
REQ-016 instr_out  out  32  fetched instruction, to the D pipeline register.
REQ-017 exc_code_out  out  5  fetch exception code; 5'd31 = none, 5'd4 = AdEL.
REQ-018 bd_out  out  1  fetched instruction is in a branch delay slot.
REQ-019 eret_flush  out  1  flush D pipeline register this cycle.

Function
REQ-020 A single 32-bit PC register SHALL hold the fetch address; pc_out and imem_addr SHALL equal it.
REQ-021 Next-PC priority per cycle SHALL be: reset -> PC_RESET; req -> HANDLER_PC (even if frozen); frozen -> hold; eret -> epc; redirect_valid -> redirect_target; else PC+4.
REQ-022 PC+4 SHALL wrap modulo 2^32 with no other effect.
REQ-023 A fetch fault SHALL exist when PC[1:0] != 0 or PC < IM_LO or PC > IM_HI.
REQ-024 On fault: exc_code_out = 5'd4, instr_out = 32'h0; otherwise exc_code_out = 5'd31, instr_out = imem_rdata.
REQ-025 Fault SHALL be evaluated on the current PC each cycle (combinational), never latched.
REQ-026 bd_out SHALL equal d_is_branch, except it SHALL be 0 when eret is high, since ERET has no delay slot.
REQ-027 eret_flush SHALL be high when eret && !frozen && !req, for exactly that cycle.
REQ-028 eret and redirect_valid together: eret wins; the redirect is discarded.
REQ-029 During frozen without req, the PC and all outputs SHALL stay stable (given stable inputs); a redirect held in D is taken on the first unfrozen cycle.
REQ-030 A faulting PC SHALL still advance normally (PC+4 or redirect); the exception is taken only via req from CP0.
REQ-031 Fetch latency: an instruction at PC appears on instr_out in the same cycle PC is registered; one instruction per unfrozen cycle.

Reset
REQ-032 On reset: PC = PC_RESET, exc_code_out = 5'd31 (PC_RESET legal), bd_out follows d_is_branch, eret_flush = 0.
REQ-033 Reset SHALL override req, eret, frozen and redirect in the same cycle.
REQ-034 No initial-block reliance; behaviour after the first reset edge is the only defined behaviour.

Structure
REQ-035 Shared package SHALL hold the exception-code constants EXC_NONE = 31 and EXC_ADEL = 4, and the default PC_RESET/HANDLER_PC values, shared with the CP0 and pipeline-register blocks.
REQ-036 One sub-module, fetch_addr_check, SHALL implement the fault test (REQ-023); everything else is in fetch_unit.

Verification
REQ-037 Reset, then 3 free cycles -> pc_out 0x3000, 0x3004, 0x3008, 0x300C; exc_code_out 31 throughout.
REQ-038 redirect_valid=1, target 0x3100, with frozen=1 for 2 cycles then 0 -> PC holds 2 cycles, then becomes 0x3100.
REQ-039 redirect target 0x3102 -> next cycle exc_code_out=4, instr_out=0; the following cycle pc_out=0x3106.
REQ-040 frozen=1, req=1 at PC 0x3010 -> next pc_out=0x4180, eret_flush=0.
REQ-041 eret=1, epc=0x3020, redirect_valid=1 (target 0x3400) -> eret_flush=1, bd_out=0, next pc_out=0x3020.
REQ-042 PC reaches 0x6FFC, free run -> next pc_out 0x7000 with exc_code_out=4.
